// File: rtl/midi_tx.sv
// MIDI transmitter: turns note on/off and program change commands into MIDI bytes
// (with optional running status) and serialises them as 8N1 UART frames.
module midi_tx #(
  parameter int unsigned CLKS_PER_BIT   = 3200,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [3:0] CHANNEL,
  input  logic       REQ,
  input  logic [1:0] CMD,
  input  logic [6:0] NOTE_NUM,
  input  logic [6:0] NOTE_VEL,
  input  logic [6:0] PROGRAM,
  output logic       READY,
  output logic       TX,
  output logic [7:0] DATA,
  output logic       DV
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_idx_q, last_idx_d;
  logic [2:0][7:0] msg_q, msg_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic [7:0]      last_status_q, last_status_d;
  logic            last_valid_q, last_valid_d;

  logic [7:0] status;
  logic       skip_status;
  logic       bit_end;

  always_comb begin
    status      = {1'b1, (CMD == 2'd2) ? 3'b100 : {2'b00, CMD[0]}, CHANNEL};
    skip_status = RUNNING_STATUS && last_valid_q && (status == last_status_q);
    bit_end     = (cnt_q == CntMax);

    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    msg_d         = msg_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    data_d        = data_q;
    dv_d          = dv_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;

    // Everything, including the DV flag, is frozen while CE is low.
    if (CE) begin
      dv_d = (state_q == StLoad);
      if (state_q == StStart || state_q == StData || state_q == StStop) begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          // CMD=3 is swallowed here: no state change, READY stays high.
          if (REQ && CMD != 2'd3) begin
            msg_d[0]   = status;
            msg_d[1]   = {1'b0, (CMD == 2'd2) ? PROGRAM : NOTE_NUM};
            msg_d[2]   = {1'b0, NOTE_VEL};
            idx_d      = skip_status ? 2'd1 : 2'd0;
            last_idx_d = (CMD == 2'd2) ? 2'd1 : 2'd2;
            state_d    = StLoad;
          end
        end
        StLoad: begin
          data_d  = msg_q[idx_q];
          shift_d = msg_q[idx_q];
          if (idx_q == 2'd0) begin
            last_status_d = msg_q[0];
            last_valid_d  = 1'b1;
          end
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = StStart;
        end
        StStart: begin
          if (bit_end) begin
            tx_d    = shift_q[0];
            bit_d   = 3'd0;
            state_d = StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = StStop;
            end else begin
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
              bit_d   = bit_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            if (idx_q == last_idx_q) begin
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StLoad;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= 3'd0;
      idx_q         <= 2'd0;
      last_idx_q    <= 2'd0;
      msg_q         <= '0;
      shift_q       <= 8'd0;
      tx_q          <= 1'b1;
      data_q        <= 8'd0;
      dv_q          <= 1'b0;
      last_status_q <= 8'd0;
      last_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      msg_q         <= msg_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      data_q        <= data_d;
      dv_q          <= dv_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
    end
  end

  assign READY = (state_q == StIdle);
  assign TX    = tx_q;
  assign DATA  = data_q;
  assign DV    = dv_q & CE;

endmodule
